// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver for the Bluetooth command link.
// It deserializes one frame on RX and holds the byte with a sticky rdy flag
// until the consumer acknowledges it. It also reports framing errors and overruns.
module uart_cmd_rx #(
    parameter int CLKS_PER_BIT = 2604   // clk cycles per bit; even and >= 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    // Synchronizer and edge-detect flops. They idle high, like the line.
    logic rx_meta_q;
    logic rx_sync_q;
    logic rx_prev_q;

    state_e           state_q;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [3:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic [7:0]       rx_data_q;
    logic             rdy_q;
    logic             frm_err_q;
    logic             ovr_err_q;

    logic fall_edge;
    logic sample_tick;

    assign fall_edge   = rx_prev_q & ~rx_sync_q;
    assign sample_tick = (baud_cnt_q == '0);

    // Bring the asynchronous pin into the clk domain, and keep one extra stage for edge detection.
    // NOTE: sequential state uses non-blocking assignments, so every flop in
    // the chain samples the previous value of the flop in front of it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Frame FSM with baud and bit counters. It also drives the registered output flags.
    // NOTE: the reset is synchronous, so it is tested inside the clocked branch
    // and rst_n is left out of the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rdy_q      <= 1'b0;
            frm_err_q  <= 1'b0;
            ovr_err_q  <= 1'b0;
        end else begin
            // NOTE: the acknowledge is applied first. A good stop sample later in
            // this block assigns rdy/ovr_err again, and the last assignment wins.
            if (clr_rdy) begin
                rdy_q     <= 1'b0;
                ovr_err_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (fall_edge) begin
                        baud_cnt_q <= HALF_RELOAD;
                        state_q    <= S_START;
                    end
                end

                S_START: begin
                    if (sample_tick) begin
                        baud_cnt_q <= FULL_RELOAD;
                        if (!rx_sync_q) begin
                            bit_cnt_q <= 4'd0;
                            state_q   <= S_DATA;
                        end else begin
                            state_q   <= S_IDLE;   // glitch, not a real start bit
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (sample_tick) begin
                        baud_cnt_q <= FULL_RELOAD;
                        shift_q    <= {rx_sync_q, shift_q[7:1]};
                        bit_cnt_q  <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            state_q <= S_STOP;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (sample_tick) begin
                        baud_cnt_q <= FULL_RELOAD;
                        state_q    <= S_IDLE;
                        if (rx_sync_q) begin
                            rx_data_q <= shift_q;
                            rdy_q     <= 1'b1;
                            frm_err_q <= 1'b0;
                            if (rdy_q && !clr_rdy) begin
                                ovr_err_q <= 1'b1;
                            end
                        end else begin
                            frm_err_q <= 1'b1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - CNT_W'(1);
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;
    assign frm_err = frm_err_q;
    assign ovr_err = ovr_err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: drives ideal 8N1 frames into uart_cmd_rx and compares the
// outputs against a frame-level reference model of the receiver's output flags.
module tb_uart_cmd_rx;

    localparam int N     = 16;
    localparam int H     = N / 2;
    localparam int FRAME = 10 * N;
    // Negedge index, counted from the start-bit drive, at which outputs first show the frame.
    localparam int DONE  = 3 + H + 9 * N;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;
    logic       ovr_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the values the outputs should currently show.
    logic [7:0] m_data;
    logic       m_rdy;
    logic       m_frm;
    logic       m_ovr;

    uart_cmd_rx #(.CLKS_PER_BIT(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err),
        .ovr_err (ovr_err)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rx_data"}, rx_data, m_data);
        check({tag, ".rdy"},     {7'd0, rdy},     {7'd0, m_rdy});
        check({tag, ".frm_err"}, {7'd0, frm_err}, {7'd0, m_frm});
        check({tag, ".ovr_err"}, {7'd0, ovr_err}, {7'd0, m_ovr});
    endtask

    // Model of a completed frame: what the consumer-visible flags become.
    task automatic model_frame(input logic [7:0] b, input logic stop_bit, input logic clr);
        if (stop_bit) begin
            m_ovr  = clr ? 1'b0 : (m_rdy ? 1'b1 : m_ovr);
            m_data = b;
            m_rdy  = 1'b1;
            m_frm  = 1'b0;
        end else begin
            m_frm = 1'b1;
            if (clr) begin
                m_rdy = 1'b0;
                m_ovr = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        m_data = 8'h00;
        m_rdy  = 1'b0;
        m_frm  = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // Line level at a given cycle of an ideal frame.
    function automatic logic line_bit(input int j, input logic [7:0] b, input logic stop_bit);
        int slot;
        slot = j / N;
        if (slot == 0) return 1'b0;
        if (slot == 9) return stop_bit;
        return b[slot - 1];
    endfunction

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            RX = 1'b1;
        end
    endtask

    // One ideal frame. Outputs are checked one cycle before they should move and again once they have moved.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input logic clr_at_stop, input string tag);
        for (int j = 0; j < FRAME; j++) begin
            @(negedge clk);
            if (j == DONE - 1) begin
                check_all({tag, ".before"});
                clr_rdy = clr_at_stop;
            end
            if (j == DONE) begin
                clr_rdy = 1'b0;
                model_frame(b, stop_bit, clr_at_stop);
                check_all({tag, ".done"});
            end
            RX = line_bit(j, b, stop_bit);
        end
    endtask

    task automatic clr_pulse(input string tag);
        @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        m_rdy   = 1'b0;
        m_ovr   = 1'b0;
        check_all(tag);
    endtask

    task automatic glitch(input int len, input string tag);
        repeat (len) begin
            @(negedge clk);
            RX = 1'b0;
        end
        idle(2 * N);
        check_all(tag);
    endtask

    initial begin
        logic [7:0] b;
        logic       stop_bit;
        logic       clr;
        logic       prev_bad;
        int         gap;

        RX      = 1'b1;
        clr_rdy = 1'b0;
        rst_n   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        idle(4);

        // Single byte, then acknowledge.
        send_frame(8'h67, 1'b1, 1'b0, "single");
        clr_pulse("single.clr");

        // Two frames back-to-back without acknowledge: overrun.
        idle(4);
        send_frame(8'h73, 1'b1, 1'b0, "ovr1");
        send_frame(8'hA5, 1'b1, 1'b0, "ovr2");
        clr_pulse("ovr.clr");

        // Short low pulse is rejected; a following frame is still received.
        idle(4);
        glitch(4, "glitch");
        send_frame(8'h5A, 1'b1, 1'b0, "after_glitch");
        clr_pulse("after_glitch.clr");

        // Bad stop bit, then a good frame.
        idle(4);
        send_frame(8'hFF, 1'b0, 1'b0, "frm_bad");
        idle(4);
        send_frame(8'h67, 1'b1, 1'b0, "frm_good");

        // Acknowledge coincides with the stop sample of a second frame.
        send_frame(8'h3C, 1'b1, 1'b1, "clr_coinc");
        clr_pulse("clr_coinc.clr");

        // Set every output flag, then reset during data bit 4.
        idle(4);
        send_frame(8'h81, 1'b1, 1'b0, "pre_rst1");
        send_frame(8'h42, 1'b1, 1'b0, "pre_rst2");
        idle(4);
        send_frame(8'h00, 1'b0, 1'b0, "pre_rst3");
        idle(4);
        for (int j = 0; j < 5 * N + 8; j++) begin
            @(negedge clk);
            RX = line_bit(j, 8'hC3, 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        RX    = 1'b1;
        @(negedge clk);
        model_reset();
        check_all("rst_mid");
        rst_n = 1'b1;
        idle(4);
        send_frame(8'h73, 1'b1, 1'b0, "after_rst");

        // Random frames, stop bits, gaps, acknowledges and glitches.
        prev_bad = 1'b0;
        for (int k = 0; k < 24; k++) begin
            b        = 8'($urandom);
            stop_bit = ($urandom_range(0, 3) != 0);
            clr      = ($urandom_range(0, 3) == 0);
            gap      = prev_bad ? $urandom_range(2, 10) : $urandom_range(0, 10);
            if ($urandom_range(0, 4) == 0) begin
                idle(2);
                glitch($urandom_range(1, H - 1), $sformatf("rnd%0d.glitch", k));
                gap = 2;
            end
            idle(gap);
            send_frame(b, stop_bit, clr, $sformatf("rnd%0d", k));
            prev_bad = !stop_bit;
            if ($urandom_range(0, 2) == 0) begin
                clr_pulse($sformatf("rnd%0d.clr", k));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
